mem_bus_arbiter: RTL and testbench

//  Shares the single memory bus between the icache miss port and the dcache miss port.

---
 rtl/mem_bus_pkg.sv | 9 +
 rtl/rr_arbiter2.sv | 26 ++
 rtl/mem_bus_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types and constants for the memory bus arbiter
package mem_bus_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic        OWNER_IC  = 1'b0;
  localparam logic        OWNER_DC  = 1'b1;
  localparam int          TAG_READ  = 12;
  localparam logic [63:0] LINE_MASK = ~64'h3F;
endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter; priority only rotates on contention
module rr_arbiter2
  import mem_bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);
  logic prio;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req == 2'b11) grant = (prio == OWNER_DC) ? 2'b10 : 2'b01;
      else              grant = req;
    end
  end

  // A lone requester is served without disturbing whose turn it is on the next tie.
  always_ff @(posedge clk) begin
    if (reset)                     prio <= OWNER_IC;
    else if (en && req == 2'b11)   prio <= ~prio;
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares the memory bus between icache and dcache line fills
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LINE_BEATS     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ic_req_valid,
  input  logic [63:0]               ic_req_addr,
  output logic                      ic_req_ready,
  output logic                      ic_resp_valid,
  output logic [BUS_DATA_WIDTH-1:0] ic_resp_data,
  output logic                      ic_resp_last,
  input  logic                      dc_req_valid,
  input  logic [63:0]               dc_req_addr,
  output logic                      dc_req_ready,
  output logic                      dc_resp_valid,
  output logic [BUS_DATA_WIDTH-1:0] dc_resp_data,
  output logic                      dc_resp_last,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack
);
  localparam int CNT_W = $clog2(LINE_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

  state_t                    state;
  logic [1:0]                grant;
  logic                      owner_q;
  logic [BUS_DATA_WIDTH-1:0] line_q;
  logic [BUS_TAG_WIDTH-1:0]  tag_q;
  logic [CNT_W-1:0]          beat_cnt;
  logic [BUS_DATA_WIDTH-1:0] resp_data_q;
  logic                      resp_last_q;
  logic                      ic_valid_q;
  logic                      dc_valid_q;
  logic [63:0]               win_line;
  logic [BUS_TAG_WIDTH-1:0]  win_tag;
  logic                      beat_hit;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({dc_req_valid, ic_req_valid}),
    .en    (state == IDLE && !reset),
    .grant (grant)
  );

  assign ic_req_ready = grant[0];
  assign dc_req_ready = grant[1];

  always_comb begin
    win_line = (grant[1] ? dc_req_addr : ic_req_addr) & LINE_MASK;
    win_tag = '0;
    win_tag[TAG_READ] = 1'b1;
    win_tag[0] = grant[1];
  end

  assign bus_reqcyc  = (state == REQ);
  assign bus_req     = line_q;
  assign bus_reqtag  = tag_q;
  assign bus_respack = (state == RESP) && bus_respcyc;
  // Beats carrying another transaction's tag are acked but never counted.
  assign beat_hit    = bus_respack && (bus_resptag == tag_q);

  assign ic_resp_valid = ic_valid_q;
  assign dc_resp_valid = dc_valid_q;
  assign ic_resp_data  = ic_valid_q ? resp_data_q : '0;
  assign dc_resp_data  = dc_valid_q ? resp_data_q : '0;
  assign ic_resp_last  = ic_valid_q && resp_last_q;
  assign dc_resp_last  = dc_valid_q && resp_last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner_q     <= OWNER_IC;
      line_q      <= '0;
      tag_q       <= '0;
      beat_cnt    <= '0;
      resp_data_q <= '0;
      resp_last_q <= 1'b0;
      ic_valid_q  <= 1'b0;
      dc_valid_q  <= 1'b0;
    end else begin
      ic_valid_q <= 1'b0;
      dc_valid_q <= 1'b0;
      case (state)
        IDLE: if (|grant) begin
          line_q  <= win_line[BUS_DATA_WIDTH-1:0];
          tag_q   <= win_tag;
          owner_q <= grant[1];
          state   <= REQ;
        end
        REQ: if (bus_reqack) begin
          beat_cnt <= '0;
          state    <= RESP;
        end
        RESP: if (beat_hit) begin
          ic_valid_q  <= (owner_q == OWNER_IC);
          dc_valid_q  <= (owner_q == OWNER_DC);
          resp_data_q <= bus_resp;
          resp_last_q <= (beat_cnt == LAST_BEAT);
          if (beat_cnt == LAST_BEAT) begin
            beat_cnt <= '0;
            state    <= IDLE;
          end else begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        ic_req_valid, dc_req_valid;
  logic [63:0] ic_req_addr, dc_req_addr;
  logic        ic_req_ready, dc_req_ready;
  logic        ic_resp_valid, dc_resp_valid, ic_resp_last, dc_resp_last;
  logic [63:0] ic_resp_data, dc_resp_data;
  logic        bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
  logic [63:0] bus_req, bus_resp;
  logic [12:0] bus_reqtag, bus_resptag;

  int tests = 0;
  int fails = 0;

  mem_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data), .ic_resp_last(ic_resp_last),
    .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr), .dc_req_ready(dc_req_ready),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data), .dc_resp_last(dc_resp_last),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
    .bus_respack(bus_respack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ic_ready"}, ic_req_ready, 0);
    chk({tag, "_dc_ready"}, dc_req_ready, 0);
    chk({tag, "_ic_valid"}, ic_resp_valid, 0);
    chk({tag, "_dc_valid"}, dc_resp_valid, 0);
    chk({tag, "_ic_data"}, ic_resp_data, 0);
    chk({tag, "_dc_data"}, dc_resp_data, 0);
    chk({tag, "_ic_last"}, ic_resp_last, 0);
    chk({tag, "_dc_last"}, dc_resp_last, 0);
    chk({tag, "_reqcyc"}, bus_reqcyc, 0);
    chk({tag, "_req"}, bus_req, 0);
    chk({tag, "_reqtag"}, bus_reqtag, 0);
    chk({tag, "_respack"}, bus_respack, 0);
  endtask

  task automatic check_resp(input logic own, input logic pv, input logic [63:0] pd, input logic pl);
    chk(own ? "dc_resp_valid" : "ic_resp_valid", own ? dc_resp_valid : ic_resp_valid, pv);
    chk(own ? "ic_resp_valid_other" : "dc_resp_valid_other", own ? ic_resp_valid : dc_resp_valid, 0);
    if (pv) begin
      chk("resp_data", own ? dc_resp_data : ic_resp_data, pd);
      chk("resp_last", own ? dc_resp_last : ic_resp_last, pl);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the ack edge.
  task automatic request(input logic own, input logic [63:0] addr, input logic [63:0] line,
                         input int ack_dly);
    logic [12:0] tg;
    tg = own ? 13'h1001 : 13'h1000;
    if (own) begin dc_req_valid = 1; dc_req_addr = addr; end
    else     begin ic_req_valid = 1; ic_req_addr = addr; end
    #1;
    chk("grant_ready", own ? dc_req_ready : ic_req_ready, 1);
    chk("grant_other_ready", own ? ic_req_ready : dc_req_ready, 0);
    @(negedge clk);
    if (own) dc_req_valid = 0; else ic_req_valid = 0;
    for (int i = 0; i <= ack_dly; i++) begin
      if (i > 0) @(negedge clk);
      if (i == ack_dly) bus_reqack = 1;
      #1;
      chk("req_cyc", bus_reqcyc, 1);
      chk("req_addr", bus_req, line);
      chk("req_tag", bus_reqtag, tg);
      chk("req_no_ready", {ic_req_ready, dc_req_ready}, 0);
    end
    @(negedge clk);
    bus_reqack = 0;
    #1 chk("req_cyc_after_ack", bus_reqcyc, 0);
  endtask

  // Drives nb matching beats base+k; optional one-cycle gaps and one foreign-tag beat.
  task automatic fill_resp(input logic own, input bit gaps, input int bad_at,
                           input logic [63:0] base, input int nb);
    logic [12:0] tg;
    logic        pv, pl;
    logic [63:0] pd;
    int          k, cyc;
    tg = own ? 13'h1001 : 13'h1000;
    k = 0; cyc = 0; pv = 0; pd = 0; pl = 0;
    while (k < nb && cyc < 100) begin
      if (cyc > 0) @(negedge clk);
      check_resp(own, pv, pd, pl);
      pv = 0;
      if (gaps && (cyc % 2 == 1)) begin
        bus_respcyc = 0;
      end else if (cyc == bad_at) begin
        bus_respcyc = 1; bus_resptag = tg ^ 13'h0001; bus_resp = 64'hDEAD_BEEF;
      end else begin
        bus_respcyc = 1; bus_resptag = tg; bus_resp = base + 64'(k);
        pv = 1; pd = base + 64'(k); pl = (k == 7); k++;
      end
      #1 chk("respack", bus_respack, bus_respcyc);
      cyc++;
    end
    chk("fill_beats", k, nb);
    @(negedge clk);
    check_resp(own, pv, pd, pl);
    if (nb == 8) begin
      #1 chk("stray_respack_idle", bus_respack, 0);
      bus_respcyc = 0;
    end
  endtask

  initial begin
    reset = 1; ic_req_valid = 0; dc_req_valid = 0; ic_req_addr = 0; dc_req_addr = 0;
    bus_reqack = 0; bus_respcyc = 0; bus_resp = 0; bus_resptag = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    #1 check_zero("reset");

    request(0, 64'h1234, 64'h1200, 3);
    fill_resp(0, 0, -1, 64'h0, 8);

    dc_req_valid = 1; dc_req_addr = 64'h8000_0FC8;
    request(0, 64'hABCD_EF7F, 64'hABCD_EF40, 20);
    fill_resp(0, 0, 3, 64'h100, 8);

    request(1, 64'h8000_0FC8, 64'h8000_0FC0, 1);
    fill_resp(1, 1, -1, 64'h200, 8);

    ic_req_valid = 1; ic_req_addr = 64'h40;
    request(1, 64'h7F, 64'h40, 2);
    fill_resp(1, 0, -1, 64'h300, 8);
    request(0, 64'h40, 64'h40, 0);
    fill_resp(0, 0, -1, 64'h400, 8);

    request(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFC0, 1);
    fill_resp(0, 0, -1, 64'h500, 4);
    reset = 1;
    @(negedge clk);
    reset = 0; bus_respcyc = 0;
    #1 check_zero("midfill_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus_respcyc = 1; bus_resptag = 13'h1000; bus_resp = 64'h5A5A;
      #1;
      chk("post_reset_respack", bus_respack, 0);
      chk("post_reset_ic_valid", ic_resp_valid, 0);
      chk("post_reset_dc_valid", dc_resp_valid, 0);
    end
    bus_respcyc = 0;
    @(negedge clk);
    request(1, 64'h1234_5678, 64'h1234_5640, 2);
    fill_resp(1, 0, -1, 64'h600, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
